// File: rtl/dma_engine.sv
// dma_engine: disk-to-main-memory word DMA controller with a four-register CPU interface.
// Each word is a DISK_RD/MEM_WR pair; busy spans the transfer and irq pulses once in DONE.
module dma_engine #(
   parameter int MEM_AW = 15,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_wr_en,
   input  logic              reg_rd_en,
   input  logic [1:0]        reg_addr,
   input  logic [DATA_W-1:0] reg_wdata,
   output logic [DATA_W-1:0] reg_rdata,
   output logic              disk_req,
   output logic [DATA_W-1:0] disk_addr,
   input  logic              disk_ack,
   input  logic [DATA_W-1:0] disk_rdata,
   output logic              mem_req,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_done,
   output logic              busy,
   output logic              irq
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DISK_RD = 2'd1,
      ST_MEM_WR  = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   disk_reg_q, disk_reg_d;
   logic [MEM_AW-1:0]   mem_reg_q, mem_reg_d;
   logic [DATA_W-1:0]   tsize_q, tsize_d;
   logic [DATA_W-1:0]   cur_disk_q, cur_disk_d;
   logic [MEM_AW-1:0]   cur_mem_q, cur_mem_d;
   logic [DATA_W-3:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   buf_q, buf_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                busy_s;
   logic                start_s;

   assign busy_s = (state_q == ST_DISK_RD) || (state_q == ST_MEM_WR);

   // Register file writes/reads, then the transfer state machine.
   always_comb begin
      state_d    = state_q;
      disk_reg_d = disk_reg_q;
      mem_reg_d  = mem_reg_q;
      tsize_d    = tsize_q;
      cur_disk_d = cur_disk_q;
      cur_mem_d  = cur_mem_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      rdata_d    = rdata_q;
      start_s    = 1'b0;

      if (reg_wr_en && !busy_s) begin
         case (reg_addr)
            2'd0:    disk_reg_d = {reg_wdata[DATA_W-1:2], 2'b00};
            2'd1:    mem_reg_d  = {reg_wdata[MEM_AW-1:2], 2'b00};
            2'd2:    tsize_d    = reg_wdata;
            2'd3:    start_s    = reg_wdata[0] && (state_q == ST_IDLE);
            default: start_s    = 1'b0;
         endcase
      end else begin
         start_s = 1'b0;
      end

      // Reads sample the pre-write register values, so a same-cycle write/read returns the old value.
      if (reg_rd_en) begin
         case (reg_addr)
            2'd0:    rdata_d = disk_reg_q;
            2'd1:    rdata_d = {{(DATA_W-MEM_AW){1'b0}}, mem_reg_q};
            2'd2:    rdata_d = tsize_q;
            2'd3:    rdata_d = {{(DATA_W-1){1'b0}}, busy_s};
            default: rdata_d = rdata_q;
         endcase
      end else begin
         rdata_d = rdata_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               cur_disk_d = disk_reg_q;
               cur_mem_d  = mem_reg_q;
               cnt_d      = tsize_q[DATA_W-1:2];
               state_d    = (tsize_q[DATA_W-1:2] == (DATA_W-2)'(0)) ? ST_DONE : ST_DISK_RD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DISK_RD: begin
            if (disk_ack) begin
               buf_d   = disk_rdata;
               state_d = ST_MEM_WR;
            end else begin
               state_d = ST_DISK_RD;
            end
         end
         ST_MEM_WR: begin
            if (mem_done) begin
               cur_disk_d = cur_disk_q + DATA_W'(4);
               cur_mem_d  = cur_mem_q + MEM_AW'(4);
               cnt_d      = cnt_q - (DATA_W-2)'(1);
               state_d    = (cnt_q == (DATA_W-2)'(1)) ? ST_DONE : ST_DISK_RD;
            end else begin
               state_d = ST_MEM_WR;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers, all cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         disk_reg_q <= '0;
         mem_reg_q  <= '0;
         tsize_q    <= '0;
         cur_disk_q <= '0;
         cur_mem_q  <= '0;
         cnt_q      <= '0;
         buf_q      <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         disk_reg_q <= disk_reg_d;
         mem_reg_q  <= mem_reg_d;
         tsize_q    <= tsize_d;
         cur_disk_q <= cur_disk_d;
         cur_mem_q  <= cur_mem_d;
         cnt_q      <= cnt_d;
         buf_q      <= buf_d;
         rdata_q    <= rdata_d;
      end
   end

   assign disk_req  = (state_q == ST_DISK_RD);
   assign mem_req   = (state_q == ST_MEM_WR);
   assign disk_addr = cur_disk_q;
   assign mem_addr  = cur_mem_q;
   assign mem_wdata = buf_q;
   assign busy      = busy_s;
   assign irq       = (state_q == ST_DONE);
   assign reg_rdata = rdata_q;

endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: stimulus queues expected requests, a monitor checks them.
module tb_dma_engine;
   localparam int MEM_AW = 15;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              reg_wr_en, reg_rd_en;
   logic [1:0]        reg_addr;
   logic [31:0]       reg_wdata, reg_rdata;
   logic              disk_req, disk_ack, mem_req, mem_done, busy, irq;
   logic [31:0]       disk_addr, disk_rdata, mem_wdata;
   logic [MEM_AW-1:0] mem_addr;

   always #5 clk = ~clk;

   dma_engine #(.MEM_AW(MEM_AW), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .disk_req(disk_req), .disk_addr(disk_addr), .disk_ack(disk_ack), .disk_rdata(disk_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done),
      .busy(busy), .irq(irq)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0;
   int start_cyc = 0;
   int disk_dly = 0;
   int mem_dly = 0;
   int done_cnt = 0;
   logic rd_pend = 1'b0;

   logic [31:0] exp_disk_q[$];
   logic [31:0] disk_data_q[$];
   logic [31:0] exp_maddr_q[$];
   logic [31:0] exp_mdata_q[$];
   logic [31:0] exp_rd_q[$];
   int          exp_irq_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event occurred, expected none", name);
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_pend <= reg_rd_en & ~rst;
   end

   // Disk model: ack after disk_dly extra cycles, returning the next queued word.
   initial begin
      int dwait;
      dwait = 0; disk_ack = 1'b0; disk_rdata = 32'h0;
      forever begin
         @(negedge clk);
         disk_ack = 1'b0;
         if (disk_req && !rst) begin
            if (dwait == disk_dly) begin
               disk_ack = 1'b1;
               if (disk_data_q.size() == 0) begin
                  flag("disk data underflow");
                  disk_rdata = 32'hDEAD_BEEF;
               end else begin
                  disk_rdata = disk_data_q.pop_front();
               end
               dwait = 0;
            end else begin
               dwait++;
            end
         end else begin
            dwait = 0;
         end
      end
   end

   // Memory model: done after mem_dly extra cycles.
   initial begin
      int mwait;
      mwait = 0; mem_done = 1'b0;
      forever begin
         @(negedge clk);
         mem_done = 1'b0;
         if (mem_req && !rst) begin
            if (mwait == mem_dly) begin
               mem_done = 1'b1;
               done_cnt++;
               mwait = 0;
            end else begin
               mwait++;
            end
         end else begin
            mwait = 0;
         end
      end
   end

   logic        mon_pd, mon_pm, mon_pi;
   logic [31:0] mon_hd, mon_hma, mon_hmd;
   int          mon_bcnt, mon_e;

   // Monitor: compares every DUT output event against the scoreboard queues.
   initial begin
      mon_pd = 1'b0; mon_pm = 1'b0; mon_pi = 1'b0; mon_bcnt = 0;
      mon_hd = 32'h0; mon_hma = 32'h0; mon_hmd = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_pd = 1'b0; mon_pm = 1'b0; mon_pi = 1'b0; mon_bcnt = 0;
         end else begin
            if (rd_pend) begin
               if (exp_rd_q.size() == 0) flag("unexpected reg read");
               else check("reg_rdata", reg_rdata, exp_rd_q.pop_front());
            end
            if (disk_req && mem_req) flag("disk_req and mem_req together");
            if (disk_req) begin
               if (!mon_pd) begin
                  if (exp_disk_q.size() == 0) begin
                     flag("unexpected disk_req");
                     mon_hd = disk_addr;
                  end else begin
                     mon_hd = exp_disk_q.pop_front();
                     check("disk_addr", disk_addr, mon_hd);
                  end
               end else begin
                  check("disk_addr held", disk_addr, mon_hd);
               end
            end
            if (mem_req) begin
               if (!mon_pm) begin
                  if (exp_maddr_q.size() == 0) begin
                     flag("unexpected mem_req");
                     mon_hma = 32'(mem_addr);
                     mon_hmd = mem_wdata;
                  end else begin
                     mon_hma = exp_maddr_q.pop_front();
                     mon_hmd = exp_mdata_q.pop_front();
                     check("mem_addr", 32'(mem_addr), mon_hma);
                     check("mem_wdata", mem_wdata, mon_hmd);
                  end
               end else begin
                  check("mem_addr held", 32'(mem_addr), mon_hma);
                  check("mem_wdata held", mem_wdata, mon_hmd);
               end
            end
            if (busy) mon_bcnt++;
            if (irq) begin
               if (mon_pi) flag("irq longer than one cycle");
               if (exp_irq_q.size() == 0) begin
                  flag("unexpected irq");
               end else begin
                  mon_e = exp_irq_q.pop_front();
                  check("busy cycles", 32'(mon_bcnt), 32'(mon_e));
                  check("irq latency", 32'(cyc - start_cyc), 32'(mon_e));
               end
               check("busy low during irq", 32'(busy), 32'd0);
               mon_bcnt = 0;
            end
            mon_pd = disk_req;
            mon_pm = mem_req;
            mon_pi = irq;
         end
      end
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      reg_wr_en = 1'b1; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      reg_wr_en = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp);
      @(negedge clk);
      reg_rd_en = 1'b1; reg_addr = a;
      exp_rd_q.push_back(exp);
      @(negedge clk);
      reg_rd_en = 1'b0;
   endtask

   task automatic wr_rd(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp_old);
      @(negedge clk);
      reg_wr_en = 1'b1; reg_rd_en = 1'b1; reg_addr = a; reg_wdata = d;
      exp_rd_q.push_back(exp_old);
      @(negedge clk);
      reg_wr_en = 1'b0; reg_rd_en = 1'b0;
   endtask

   task automatic start();
      @(negedge clk);
      reg_wr_en = 1'b1; reg_addr = 2'd3; reg_wdata = 32'h1;
      start_cyc = cyc + 1;
      @(negedge clk);
      reg_wr_en = 1'b0;
   endtask

   task automatic exp_word(input logic [31:0] da, input logic [31:0] ma, input logic [31:0] d);
      exp_disk_q.push_back(da);
      disk_data_q.push_back(d);
      exp_maddr_q.push_back(ma);
      exp_mdata_q.push_back(d);
   endtask

   task automatic wait_done(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clk); #1;
         if (exp_irq_q.size() == 0 && !busy) break;
      end
      if (i == budget) flag("timeout waiting for irq");
      repeat (3) @(negedge clk);
      check("disk requests drained", 32'(exp_disk_q.size()), 32'd0);
      check("mem writes drained", 32'(exp_maddr_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1; reg_wr_en = 1'b0; reg_rd_en = 1'b0; reg_addr = 2'd0; reg_wdata = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      check("reset disk_req", 32'(disk_req), 32'd0);
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset irq", 32'(irq), 32'd0);
      check("reset disk_addr", disk_addr, 32'h0);
      check("reset mem_addr", 32'(mem_addr), 32'h0);
      check("reset mem_wdata", mem_wdata, 32'h0);
      check("reset reg_rdata", reg_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      rd(2'd3, 32'h0);

      // Basic 4-word transfer with immediate handshakes.
      wr(2'd0, 32'h100); wr(2'd1, 32'h200); wr(2'd2, 32'd16);
      exp_word(32'h100, 32'h200, 32'hA0);
      exp_word(32'h104, 32'h204, 32'hA1);
      exp_word(32'h108, 32'h208, 32'hA2);
      exp_word(32'h10C, 32'h20C, 32'hA3);
      exp_irq_q.push_back(8);
      start();
      wait_done(100);
      rd(2'd3, 32'h0);

      // T_SIZE=7 moves exactly one word.
      wr(2'd2, 32'd7);
      exp_word(32'h100, 32'h200, 32'hB0);
      exp_irq_q.push_back(2);
      start();
      wait_done(100);

      // T_SIZE=0: irq the cycle after INIT, no requests.
      wr(2'd2, 32'd0);
      exp_irq_q.push_back(0);
      start();
      wait_done(100);
      wr_rd(2'd2, 32'h7, 32'h0);
      rd(2'd2, 32'h7);

      // Address alignment and wrap of both address counters.
      wr(2'd0, 32'hFFFF_FFFF); wr(2'd1, 32'hFFFF_7FFF); wr(2'd2, 32'd8);
      rd(2'd0, 32'hFFFF_FFFC);
      rd(2'd1, 32'h0000_7FFC);
      exp_word(32'hFFFF_FFFC, 32'h7FFC, 32'hC0);
      exp_word(32'h0000_0000, 32'h0000, 32'hC1);
      exp_irq_q.push_back(4);
      start();
      wait_done(100);

      // Backpressure plus register protection while busy.
      disk_dly = 3; mem_dly = 5;
      wr(2'd0, 32'h100); wr(2'd1, 32'h200); wr(2'd2, 32'd8);
      exp_word(32'h100, 32'h200, 32'hD0);
      exp_word(32'h104, 32'h204, 32'hD1);
      exp_irq_q.push_back(20);
      start();
      wr(2'd0, 32'h0000_FFFF);
      wr(2'd2, 32'h40);
      wr(2'd3, 32'h1);
      rd(2'd3, 32'h1);
      wait_done(200);
      rd(2'd0, 32'h100);
      rd(2'd2, 32'd8);

      // A second INIT repeats the programmed transfer.
      disk_dly = 0; mem_dly = 0;
      exp_word(32'h100, 32'h200, 32'hE0);
      exp_word(32'h104, 32'h204, 32'hE1);
      exp_irq_q.push_back(4);
      start();
      wait_done(100);

      // Reset after the second mem_done of a 4-word transfer.
      wr(2'd0, 32'h300); wr(2'd1, 32'h400); wr(2'd2, 32'd16);
      exp_word(32'h300, 32'h400, 32'hF0);
      exp_word(32'h304, 32'h404, 32'hF1);
      exp_word(32'h308, 32'h408, 32'hF2);
      exp_word(32'h30C, 32'h40C, 32'hF3);
      done_cnt = 0;
      start();
      for (k = 0; k < 200; k++) begin
         @(negedge clk); #1;
         if (done_cnt >= 2) break;
      end
      if (k == 200) flag("timeout waiting for second mem_done");
      @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      check("mid-reset disk_req", 32'(disk_req), 32'd0);
      check("mid-reset mem_req", 32'(mem_req), 32'd0);
      check("mid-reset busy", 32'(busy), 32'd0);
      check("mid-reset irq", 32'(irq), 32'd0);
      check("mid-reset disk_addr", disk_addr, 32'h0);
      exp_disk_q.delete(); disk_data_q.delete(); exp_maddr_q.delete(); exp_mdata_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rd(2'd0, 32'h0);

      wr(2'd0, 32'h500); wr(2'd1, 32'h600); wr(2'd2, 32'd8);
      exp_word(32'h500, 32'h600, 32'h11);
      exp_word(32'h504, 32'h604, 32'h22);
      exp_irq_q.push_back(4);
      start();
      wait_done(100);
      check("irq queue drained", 32'(exp_irq_q.size()), 32'd0);
      check("read queue drained", 32'(exp_rd_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
